// File: rtl/sample_uart_framer_pkg.sv
// Shared FSM encoding, frame geometry and header constant for the sample framer.
// Build option FRAMER_CHECKSUM_EN appends an XOR checksum byte to every frame.
package framer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_LOAD       = 3'd1,
        ST_SEND       = 3'd2,
        ST_WAIT_BUSY  = 3'd3,
        ST_WAIT_READY = 3'd4
    } state_e;

    localparam int SAMPLE_W = 12;
    localparam int PAIR_W   = 2 * SAMPLE_W;

`ifdef FRAMER_CHECKSUM_EN
    localparam int FRAME_LEN = 6;
`else
    localparam int FRAME_LEN = 5;
`endif

    localparam int IDX_W = $clog2(FRAME_LEN);

    localparam logic [7:0] DEFAULT_HEADER = 8'hAA;

    // pair layout is {v[11:0], i[11:0]}; index 0 (and anything unused) is the header
    function automatic logic [7:0] frame_byte(input logic [7:0]        header,
                                              input logic [PAIR_W-1:0] pair,
                                              input logic [IDX_W-1:0]  idx);
        logic [7:0] b;
        case (idx)
            IDX_W'(1): b = {4'h0, pair[23:20]};
            IDX_W'(2): b = pair[19:12];
            IDX_W'(3): b = {4'h0, pair[11:8]};
            IDX_W'(4): b = pair[7:0];
`ifdef FRAMER_CHECKSUM_EN
            IDX_W'(5): b = header ^ {4'h0, pair[23:20]} ^ pair[19:12]
                                  ^ {4'h0, pair[11:8]} ^ pair[7:0];
`endif
            default:   b = header;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/sample_uart_framer_if.sv
// Bundle of sampler, UART and status signals around the framer, plus debug taps.
// Build option FRAMER_CHECKSUM_EN only changes the frame length, not this bundle.
interface sample_uart_framer_if;
    import framer_pkg::*;

    // Sampler side: sample_valid is a one-cycle strobe, no back-pressure.
    // UART side: tx_en may pulse only while tx_ready is 1; tx_ready falling
    // afterwards acknowledges the byte and rising again means the line is idle.
    logic                sample_valid;
    logic [SAMPLE_W-1:0] sample_v;
    logic [SAMPLE_W-1:0] sample_i;
    logic [7:0]          tx_byte;
    logic                tx_en;
    logic                tx_ready;
    logic                fifo_full;
    logic                overflow;
    logic [7:0]          drop_count;
    state_e              dbg_state;
    logic [7:0]          dbg_count;

    modport master (
        input  sample_valid, sample_v, sample_i, tx_ready,
        output tx_byte, tx_en, fifo_full, overflow, drop_count, dbg_state, dbg_count
    );

    modport slave (
        output sample_valid, sample_v, sample_i, tx_ready,
        input  tx_byte, tx_en, fifo_full, overflow, drop_count, dbg_state, dbg_count
    );

endinterface

// File: rtl/sample_uart_framer_fifo.sv
// Synchronous FIFO with registered read data (valid the cycle after pop).
// Push into a full FIFO succeeds only when a pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 24,
    parameter int DEPTH = 8
) (
    input  logic                   clk100,
    input  logic                   rst,
    input  logic                   push_i,
    input  logic [WIDTH-1:0]       wdata_i,
    input  logic                   pop_i,
    output logic [WIDTH-1:0]       rdata_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic [WIDTH-1:0] rdata_q;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop_i && !empty_q;
    assign do_push = push_i && (!full_q || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        full_d  = (count_d == CW'(DEPTH));
        empty_d = (count_d == '0);
    end

    always_ff @(posedge clk100 or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            rdata_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            if (do_pop) begin
                rdata_q <= mem_q[rd_ptr_q];
            end
        end
    end

    // Storage needs no reset: occupancy alone decides what is readable.
    always_ff @(posedge clk100) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    assign rdata_o = rdata_q;
    assign full_o  = full_q;
    assign empty_o = empty_q;
    assign count_o = count_q;

endmodule

// File: rtl/sample_uart_framer.sv
// Packs {v,i} sample pairs into header-led byte frames and paces them into the UART.
// Build option FRAMER_CHECKSUM_EN: 6-byte frames with a trailing XOR checksum.
module sample_uart_framer
    import framer_pkg::*;
#(
    parameter int         FIFO_DEPTH = 8,
    parameter logic [7:0] HEADER     = DEFAULT_HEADER
) (
    input logic                  clk100,
    input logic                  rst,
    sample_uart_framer_if.master bus
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [7:0]         tx_byte_q, tx_byte_d;
    logic               tx_en_q, tx_en_d;
    logic               overflow_q, overflow_d;
    logic [7:0]         drop_q, drop_d;

    logic               fifo_pop;
    logic               fifo_full;
    logic               fifo_empty;
    logic [CW-1:0]      fifo_count;
    logic [PAIR_W-1:0]  frame_pair;
    logic               drop;
    logic               last_byte;

    sync_fifo #(
        .WIDTH (PAIR_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk100  (clk100),
        .rst     (rst),
        .push_i  (bus.sample_valid),
        .wdata_i ({bus.sample_v, bus.sample_i}),
        .pop_i   (fifo_pop),
        .rdata_o (frame_pair),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // The head stays in the FIFO until the UART is free, so fifo_full and the
    // drop counter reflect every sample still waiting for the line.
    assign fifo_pop  = (state_q == ST_IDLE) && !fifo_empty && bus.tx_ready;
    assign drop      = bus.sample_valid && fifo_full && !fifo_pop;
    assign last_byte = (idx_q == IDX_W'(FRAME_LEN - 1));

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        tx_byte_d = tx_byte_q;
        tx_en_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (fifo_pop) begin
                    idx_d   = '0;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                tx_byte_d = frame_byte(HEADER, frame_pair, idx_q);
                state_d   = ST_SEND;
            end
            ST_SEND: begin
                if (bus.tx_ready) begin
                    tx_en_d = 1'b1;
                    state_d = ST_WAIT_BUSY;
                end
            end
            ST_WAIT_BUSY: begin
                if (!bus.tx_ready) begin
                    state_d = ST_WAIT_READY;
                end
            end
            ST_WAIT_READY: begin
                if (bus.tx_ready) begin
                    if (last_byte) begin
                        state_d = ST_IDLE;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = ST_LOAD;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        overflow_d = overflow_q | drop;
        drop_d     = drop_q;
        if (drop && (drop_q != 8'hFF)) begin
            drop_d = drop_q + 8'd1;
        end
    end

    always_ff @(posedge clk100 or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            tx_byte_q  <= 8'h00;
            tx_en_q    <= 1'b0;
            overflow_q <= 1'b0;
            drop_q     <= 8'h00;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            tx_byte_q  <= tx_byte_d;
            tx_en_q    <= tx_en_d;
            overflow_q <= overflow_d;
            drop_q     <= drop_d;
        end
    end

    assign bus.tx_byte    = tx_byte_q;
    assign bus.tx_en      = tx_en_q;
    assign bus.fifo_full  = fifo_full;
    assign bus.overflow   = overflow_q;
    assign bus.drop_count = drop_q;
    assign bus.dbg_state  = state_q;
    // Debug occupancy view; depths up to 128 fit in eight bits.
    assign bus.dbg_count  = 8'(fifo_count);

endmodule

// File: tb/tb_sample_uart_framer.sv
// Directed bench for sample_uart_framer: UART model with 10-cycle busy time,
// byte collector, expected-byte queue and one task per scenario.
module tb_sample_uart_framer;
    import framer_pkg::*;

    logic clk100;
    logic rst;
    logic hold_off;
    int   busy_cnt;
    int   tests_run;
    int   tests_failed;

    logic [7:0] got_mem [1024];
    int         got_n;
    logic [7:0] exp_q [$];

    sample_uart_framer_if bus ();

    sample_uart_framer #(
        .FIFO_DEPTH (8),
        .HEADER     (8'hAA)
    ) dut (
        .clk100 (clk100),
        .rst    (rst),
        .bus    (bus)
    );

    initial begin
        clk100 = 1'b0;
        forever #5 clk100 = ~clk100;
    end

    // UART model: idle unless held off; busy for 10 cycles after each tx_en.
    assign bus.tx_ready = !hold_off && (busy_cnt == 0);

    always @(negedge clk100) begin
        if (!rst) begin
            busy_cnt = 0;
        end else if (bus.tx_en) begin
            if (got_n < 1024) got_mem[got_n] = bus.tx_byte;
            got_n    = got_n + 1;
            busy_cnt = 10;
        end else if (busy_cnt > 0) begin
            busy_cnt = busy_cnt - 1;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic push(input logic [11:0] v, input logic [11:0] i);
        bus.sample_valid = 1'b1;
        bus.sample_v     = v;
        bus.sample_i     = i;
        @(negedge clk100);
        bus.sample_valid = 1'b0;
    endtask

    task automatic add_exp(input logic [11:0] v, input logic [11:0] i);
        logic [7:0] b [5];
        b[0] = 8'hAA;
        b[1] = {4'h0, v[11:8]};
        b[2] = v[7:0];
        b[3] = {4'h0, i[11:8]};
        b[4] = i[7:0];
        for (int k = 0; k < 5; k++) exp_q.push_back(b[k]);
`ifdef FRAMER_CHECKSUM_EN
        exp_q.push_back(b[0] ^ b[1] ^ b[2] ^ b[3] ^ b[4]);
`endif
    endtask

    task automatic apply_reset();
        @(negedge clk100);
        rst              = 1'b0;
        bus.sample_valid = 1'b0;
        hold_off         = 1'b0;
        repeat (3) @(negedge clk100);
        rst = 1'b1;
        @(negedge clk100);
    endtask

    task automatic wait_bytes(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(posedge clk100);
            #2;
            if (got_n >= n) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        repeat (3) @(posedge clk100);
        #1;
        tests_run++;
        if (bus.tx_en !== 1'b0) begin tests_failed++; $display("FAIL reset_tx_en: got %b want 0", bus.tx_en); end
        tests_run++;
        if (bus.tx_byte !== 8'h00) begin tests_failed++; $display("FAIL reset_tx_byte: got %h want 00", bus.tx_byte); end
        tests_run++;
        if (bus.fifo_full !== 1'b0) begin tests_failed++; $display("FAIL reset_fifo_full: got %b want 0", bus.fifo_full); end
        tests_run++;
        if (bus.overflow !== 1'b0) begin tests_failed++; $display("FAIL reset_overflow: got %b want 0", bus.overflow); end
        tests_run++;
        if (bus.drop_count !== 8'd0) begin tests_failed++; $display("FAIL reset_drop_count: got %0d want 0", bus.drop_count); end
        tests_run++;
        if (bus.dbg_count !== 8'd0) begin tests_failed++; $display("FAIL reset_fifo_count: got %0d want 0", bus.dbg_count); end
        tests_run++;
        if (bus.dbg_state !== ST_IDLE) begin tests_failed++; $display("FAIL reset_state: got %0d want 0", bus.dbg_state); end
        @(negedge clk100);
        rst = 1'b1;
        @(negedge clk100);
    endtask

    task automatic test_single_frame();
        int base;
        bit ok;
        base  = got_n;
        exp_q = {8'hAA, 8'h0A, 8'hBC, 8'h01, 8'h23};
`ifdef FRAMER_CHECKSUM_EN
        exp_q.push_back(8'hAA ^ 8'h0A ^ 8'hBC ^ 8'h01 ^ 8'h23);
`endif
        push(12'hABC, 12'h123);
        wait_bytes(base + FRAME_LEN, 200, ok);
        tests_run++;
        if (!ok) begin tests_failed++; $display("FAIL single_timeout: got %0d bytes want %0d", got_n - base, FRAME_LEN); end
        for (int k = 0; k < FRAME_LEN; k++) begin
            logic [7:0] e;
            e = exp_q.pop_front();
            tests_run++;
            if (got_mem[base + k] !== e) begin
                tests_failed++;
                $display("FAIL single_byte%0d: got %h want %h", k, got_mem[base + k], e);
            end
        end
        repeat (40) @(posedge clk100);
        #2;
        tests_run++;
        if (got_n !== base + FRAME_LEN) begin tests_failed++; $display("FAIL single_extra_bytes: got %0d want %0d", got_n - base, FRAME_LEN); end
        @(negedge clk100);
    endtask

    task automatic test_latency();
        int base;
        bit ok;
        base = got_n;
        add_exp(12'h5A5, 12'hF0F);
        bus.sample_valid = 1'b1;
        bus.sample_v     = 12'h5A5;
        bus.sample_i     = 12'hF0F;
        @(posedge clk100);              // edge 0: push
        #1;
        bus.sample_valid = 1'b0;
        @(posedge clk100);              // edge 1: pop
        @(posedge clk100);              // edge 2: LOAD
        #1;
        tests_run++;
        if (bus.tx_en !== 1'b0) begin tests_failed++; $display("FAIL latency_early: got tx_en %b want 0 after edge 2", bus.tx_en); end
        @(posedge clk100);              // edge 3: tx_en
        #1;
        tests_run++;
        if (bus.tx_en !== 1'b1) begin tests_failed++; $display("FAIL latency_tx_en: got %b want 1 after edge 3", bus.tx_en); end
        tests_run++;
        if (bus.tx_byte !== 8'hAA) begin tests_failed++; $display("FAIL latency_tx_byte: got %h want aa", bus.tx_byte); end
        wait_bytes(base + FRAME_LEN, 200, ok);
        tests_run++;
        if (!ok) begin tests_failed++; $display("FAIL latency_timeout: got %0d bytes want %0d", got_n - base, FRAME_LEN); end
        for (int k = 0; k < FRAME_LEN; k++) begin
            logic [7:0] e;
            e = exp_q.pop_front();
            tests_run++;
            if (got_mem[base + k] !== e) begin
                tests_failed++;
                $display("FAIL latency_byte%0d: got %h want %h", k, got_mem[base + k], e);
            end
        end
        repeat (20) @(negedge clk100);
    endtask

    task automatic test_overflow();
        int base;
        bit ok;
        exp_q.delete();
        base     = got_n;
        hold_off = 1'b1;
        for (int k = 0; k < 11; k++) begin
            if (k < 8) add_exp(12'h100 + 12'(k), 12'h200 + 12'(k));
            push(12'h100 + 12'(k), 12'h200 + 12'(k));
        end
        @(posedge clk100);
        #1;
        tests_run++;
        if (bus.fifo_full !== 1'b1) begin tests_failed++; $display("FAIL ovf_fifo_full: got %b want 1", bus.fifo_full); end
        tests_run++;
        if (bus.overflow !== 1'b1) begin tests_failed++; $display("FAIL ovf_overflow: got %b want 1", bus.overflow); end
        tests_run++;
        if (bus.drop_count !== 8'd3) begin tests_failed++; $display("FAIL ovf_drop_count: got %0d want 3", bus.drop_count); end
        tests_run++;
        if (bus.dbg_count !== 8'd8) begin tests_failed++; $display("FAIL ovf_fifo_count: got %0d want 8", bus.dbg_count); end
        @(negedge clk100);
        hold_off = 1'b0;
        wait_bytes(base + 8 * FRAME_LEN, 8 * FRAME_LEN * 20, ok);
        tests_run++;
        if (!ok) begin tests_failed++; $display("FAIL ovf_timeout: got %0d bytes want %0d", got_n - base, 8 * FRAME_LEN); end
        for (int k = 0; k < 8 * FRAME_LEN; k++) begin
            logic [7:0] e;
            e = exp_q.pop_front();
            tests_run++;
            if (got_mem[base + k] !== e) begin
                tests_failed++;
                $display("FAIL ovf_byte%0d: got %h want %h", k, got_mem[base + k], e);
            end
        end
        repeat (40) @(posedge clk100);
        #2;
        tests_run++;
        if (got_n !== base + 8 * FRAME_LEN) begin tests_failed++; $display("FAIL ovf_frame_count: got %0d bytes want %0d", got_n - base, 8 * FRAME_LEN); end
        tests_run++;
        if (bus.overflow !== 1'b1) begin tests_failed++; $display("FAIL ovf_sticky: got %b want 1", bus.overflow); end
        tests_run++;
        if (bus.fifo_full !== 1'b0) begin tests_failed++; $display("FAIL ovf_drained_full: got %b want 0", bus.fifo_full); end
        @(negedge clk100);
    endtask

    task automatic test_full_push_pop();
        int base;
        bit ok;
        apply_reset();
        exp_q.delete();
        base     = got_n;
        hold_off = 1'b1;
        for (int k = 0; k < 9; k++) begin
            if (k < 8) add_exp(12'h300 + 12'(k), 12'hC00 + 12'(k));
            push(12'h300 + 12'(k), 12'hC00 + 12'(k));
        end
        @(posedge clk100);
        #1;
        tests_run++;
        if (bus.drop_count !== 8'd1) begin tests_failed++; $display("FAIL fpp_pre_drop: got %0d want 1", bus.drop_count); end
        @(negedge clk100);
        hold_off         = 1'b0;
        add_exp(12'h7FF, 12'h800);
        bus.sample_valid = 1'b1;
        bus.sample_v     = 12'h7FF;
        bus.sample_i     = 12'h800;
        @(posedge clk100);
        #1;
        bus.sample_valid = 1'b0;
        tests_run++;
        if (bus.dbg_state !== ST_LOAD) begin tests_failed++; $display("FAIL fpp_popped: got state %0d want 1", bus.dbg_state); end
        tests_run++;
        if (bus.dbg_count !== 8'd8) begin tests_failed++; $display("FAIL fpp_count: got %0d want 8", bus.dbg_count); end
        tests_run++;
        if (bus.fifo_full !== 1'b1) begin tests_failed++; $display("FAIL fpp_full: got %b want 1", bus.fifo_full); end
        tests_run++;
        if (bus.drop_count !== 8'd1) begin tests_failed++; $display("FAIL fpp_drop: got %0d want 1", bus.drop_count); end
        wait_bytes(base + 9 * FRAME_LEN, 9 * FRAME_LEN * 20, ok);
        tests_run++;
        if (!ok) begin tests_failed++; $display("FAIL fpp_timeout: got %0d bytes want %0d", got_n - base, 9 * FRAME_LEN); end
        for (int k = 0; k < 9 * FRAME_LEN; k++) begin
            logic [7:0] e;
            e = exp_q.pop_front();
            tests_run++;
            if (got_mem[base + k] !== e) begin
                tests_failed++;
                $display("FAIL fpp_byte%0d: got %h want %h", k, got_mem[base + k], e);
            end
        end
        repeat (20) @(negedge clk100);
    endtask

    task automatic test_saturation();
        apply_reset();
        hold_off = 1'b1;
        for (int k = 0; k < 308; k++) push(12'(k), ~12'(k));
        @(posedge clk100);
        #1;
        tests_run++;
        if (bus.drop_count !== 8'd255) begin tests_failed++; $display("FAIL sat_drop_count: got %0d want 255", bus.drop_count); end
        tests_run++;
        if (bus.overflow !== 1'b1) begin tests_failed++; $display("FAIL sat_overflow: got %b want 1", bus.overflow); end
        @(negedge clk100);
        for (int k = 0; k < 5; k++) push(12'h0F0, 12'h00F);
        @(posedge clk100);
        #1;
        tests_run++;
        if (bus.drop_count !== 8'd255) begin tests_failed++; $display("FAIL sat_hold: got %0d want 255", bus.drop_count); end
        tests_run++;
        if (bus.dbg_count !== 8'd8) begin tests_failed++; $display("FAIL sat_fifo_count: got %0d want 8", bus.dbg_count); end
        @(negedge clk100);
    endtask

    task automatic test_reset_mid_frame();
        int base;
        int seen;
        bit ok;
        apply_reset();
        exp_q.delete();
        push(12'h111, 12'h222);
        push(12'h333, 12'h444);
        push(12'h555, 12'h666);
        seen = 0;
        for (int c = 0; c < 200; c++) begin
            @(posedge clk100);
            #1;
            if (bus.tx_en === 1'b1) seen++;
            if (seen == 2) break;
        end
        tests_run++;
        if (seen != 2) begin tests_failed++; $display("FAIL rmid_second_byte: got %0d strobes want 2", seen); end
        rst = 1'b0;
        #1;
        tests_run++;
        if (bus.tx_en !== 1'b0) begin tests_failed++; $display("FAIL rmid_tx_en_async: got %b want 0", bus.tx_en); end
        tests_run++;
        if (bus.tx_byte !== 8'h00) begin tests_failed++; $display("FAIL rmid_tx_byte: got %h want 00", bus.tx_byte); end
        tests_run++;
        if (bus.dbg_count !== 8'd0) begin tests_failed++; $display("FAIL rmid_fifo_empty: got %0d want 0", bus.dbg_count); end
        tests_run++;
        if (bus.dbg_state !== ST_IDLE) begin tests_failed++; $display("FAIL rmid_state: got %0d want 0", bus.dbg_state); end
        tests_run++;
        if (bus.fifo_full !== 1'b0 || bus.overflow !== 1'b0 || bus.drop_count !== 8'd0) begin
            tests_failed++;
            $display("FAIL rmid_status: got full %b ovf %b drops %0d want 0 0 0", bus.fifo_full, bus.overflow, bus.drop_count);
        end
        repeat (2) @(negedge clk100);
        rst = 1'b1;
        @(negedge clk100);
        base = got_n;
        add_exp(12'h9C3, 12'h07E);
        push(12'h9C3, 12'h07E);
        wait_bytes(base + FRAME_LEN, 200, ok);
        tests_run++;
        if (!ok) begin tests_failed++; $display("FAIL rmid_timeout: got %0d bytes want %0d", got_n - base, FRAME_LEN); end
        for (int k = 0; k < FRAME_LEN; k++) begin
            logic [7:0] e;
            e = exp_q.pop_front();
            tests_run++;
            if (got_mem[base + k] !== e) begin
                tests_failed++;
                $display("FAIL rmid_byte%0d: got %h want %h", k, got_mem[base + k], e);
            end
        end
        repeat (60) @(posedge clk100);
        #2;
        tests_run++;
        if (got_n !== base + FRAME_LEN) begin tests_failed++; $display("FAIL rmid_discarded: got %0d bytes want %0d", got_n - base, FRAME_LEN); end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        tests_run        = 0;
        tests_failed     = 0;
        got_n            = 0;
        busy_cnt         = 0;
        hold_off         = 1'b0;
        rst              = 1'b0;
        bus.sample_valid = 1'b0;
        bus.sample_v     = 12'h000;
        bus.sample_i     = 12'h000;

        test_reset();
        test_single_frame();
        test_latency();
        test_overflow();
        test_full_push_pop();
        test_saturation();
        test_reset_mid_frame();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
